// File: rtl/rf_seq_defs.sv
// Shared definitions for the register-file bus sequencer: width defaults,
// opcode and FSM state encodings.
package rf_seq_defs;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_SEL_W  = 4;

    typedef enum logic [2:0] {
        OP_MOV = 3'd0,
        OP_LDI = 3'd1,
        OP_ADD = 3'd2,
        OP_SUB = 3'd3,
        OP_AND = 3'd4,
        OP_OR  = 3'd5,
        OP_RD  = 3'd6,
        OP_ILL = 3'd7
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_READ_A = 3'd1,
        S_READ_B = 3'd2,
        S_EXEC   = 3'd3,
        S_WRITE  = 3'd4,
        S_RESP   = 3'd5
    } state_e;

endpackage

// File: rtl/rf_seq_alu.sv
// Combinational result generator for the sequencer's EXEC beat.
module rf_seq_alu
    import rf_seq_defs::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  op_e               op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] imm,
    output logic [DATA_W-1:0] result
);

    always_comb begin
        result = '0;
        case (op)
            OP_MOV:  result = a;
            OP_LDI:  result = imm;
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_RD:   result = a;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/rf_bus_sequencer.sv
// Sole bus master of the register file: runs one MOV/LDI/ALU/RD transfer per
// request, one bus beat per cycle, and returns the result over a handshake.
module rf_bus_sequencer
    import rf_seq_defs::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned SEL_W  = DEF_SEL_W
) (
    input  logic              clk,
    input  logic              clear_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [SEL_W-1:0]  req_rd,
    input  logic [SEL_W-1:0]  req_ra,
    input  logic [SEL_W-1:0]  req_rb,
    input  logic [DATA_W-1:0] req_imm,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              rf_write_enable,
    output logic [SEL_W-1:0]  rf_reg_select,
    output logic [DATA_W-1:0] rf_bus_out,
    input  logic [DATA_W-1:0] rf_bus_in
);

    state_e             state, state_nxt;
    op_e                op_q;
    logic [SEL_W-1:0]   rd_q, ra_q, rb_q;
    logic [DATA_W-1:0]  imm_q, a_q, b_q, z_q;
    logic [DATA_W-1:0]  alu_result;
    logic               accept;

    assign accept = (state == S_IDLE) && req_valid;

    rf_seq_alu #(.DATA_W(DATA_W)) u_alu (
        .op     (op_q),
        .a      (a_q),
        .b      (b_q),
        .imm    (imm_q),
        .result (alu_result)
    );

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // z_q is cleared on accept so an illegal op responds with zero without an EXEC beat
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            op_q  <= OP_MOV;
            rd_q  <= '0;
            ra_q  <= '0;
            rb_q  <= '0;
            imm_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
            z_q   <= '0;
        end else begin
            if (accept) begin
                op_q  <= op_e'(req_op);
                rd_q  <= req_rd;
                ra_q  <= req_ra;
                rb_q  <= req_rb;
                imm_q <= req_imm;
                z_q   <= '0;
            end
            if (state == S_READ_A) a_q <= rf_bus_in;
            if (state == S_READ_B) b_q <= rf_bus_in;
            if (state == S_EXEC)   z_q <= alu_result;
        end
    end

    always_comb begin
        state_nxt       = state;
        req_ready       = 1'b0;
        rsp_valid       = 1'b0;
        rsp_data        = '0;
        rsp_err         = 1'b0;
        rf_write_enable = 1'b0;
        rf_reg_select   = '0;
        rf_bus_out      = '0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    case (op_e'(req_op))
                        OP_LDI:  state_nxt = S_EXEC;
                        OP_ILL:  state_nxt = S_RESP;
                        default: state_nxt = S_READ_A;
                    endcase
                end
            end
            S_READ_A: begin
                rf_reg_select = ra_q;
                state_nxt = (op_q == OP_MOV || op_q == OP_RD) ? S_EXEC : S_READ_B;
            end
            S_READ_B: begin
                rf_reg_select = rb_q;
                state_nxt     = S_EXEC;
            end
            S_EXEC: begin
                state_nxt = (op_q == OP_RD) ? S_RESP : S_WRITE;
            end
            S_WRITE: begin
                rf_write_enable = 1'b1;
                rf_reg_select   = rd_q;
                rf_bus_out      = z_q;
                state_nxt       = S_RESP;
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                rsp_data  = z_q;
                rsp_err   = (op_q == OP_ILL);
                if (rsp_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule
